// File: rtl/crc16_frame_feeder.sv
// crc16_frame_feeder
// Upstream feeder for the crc16_parallel engine. Buffers framed 16-bit words
// in a small FIFO. For each frame it clears the engine, streams the words into
// it one per cycle, waits for the engine output to settle, and then presents
// the captured CRC, word count and truncation flag on a valid/ready port.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input word handshake (in_ready is registered !full)
//   in_data, in_last        input word and end-of-frame marker
//   crc_clear               one-cycle clear pulse to the engine
//   crc_enable, crc_data    engine enable and data_in
//   crc_in                  engine crc_out
//   res_valid/res_ready     frame result handshake
//   res_crc, res_len        captured CRC and number of words fed
//   res_err                 frame was truncated at MAX_LEN
module crc16_frame_feeder #(
  parameter int DEPTH   = 4,
  parameter int MAX_LEN = 256,
  parameter int LATENCY = 1,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  input  logic          in_last,
  output logic          crc_clear,
  output logic          crc_enable,
  output logic [15:0]   crc_data,
  input  logic [15:0]   crc_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_crc,
  output logic [LW-1:0] res_len,
  output logic          res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // DROP is the discard sub-mode entered after a truncated frame's result.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    DROP  = 3'd5
  } state_t;

  // FIFO storage and pointers
  logic [16:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  logic          in_ready_r;
  logic          push_s, pop_s, empty_s, head_last_s;
  logic [15:0]   head_data_s;

  // Frame control
  state_t        state_r, state_s;
  logic [LW-1:0] len_r, len_s, len_inc_s;
  logic          err_r, err_s;
  logic          drop_r, drop_s;
  logic [WW-1:0] wait_r, wait_s;
  logic          feed_s, capture_s, hs_s;
  logic [15:0]   crc_data_r;

  // Result registers
  logic          res_valid_r;
  logic [15:0]   res_crc_r;
  logic [LW-1:0] res_len_r;
  logic          res_err_r;

  assign push_s      = in_valid & in_ready_r;
  assign empty_s     = (count_r == '0);
  assign head_data_s = mem_r[rd_ptr_r][15:0];
  assign head_last_s = mem_r[rd_ptr_r][16];
  assign len_inc_s   = len_r + LW'(1);
  assign hs_s        = res_valid_r & res_ready;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO data write; storage needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_last, in_data};
    end
  end

  // FIFO pointers, count and registered ready (pointers wrap as DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r    <= count_s;
      in_ready_r <= (count_s != CW'(DEPTH));
    end
  end

  // Next-state and datapath control for the frame sequencer
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    err_s     = err_r;
    drop_s    = drop_r;
    wait_s    = wait_r;
    pop_s     = 1'b0;
    feed_s    = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A word being pushed now is stored before FEED can pop it, so the
        // clear can be issued one cycle earlier without any bypass path.
        if (!empty_s || push_s) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        len_s   = '0;
        err_s   = 1'b0;
        wait_s  = '0;
        state_s = FEED;
      end
      FEED: begin
        if (!empty_s) begin
          pop_s  = 1'b1;
          feed_s = 1'b1;
          len_s  = len_inc_s;
          if (head_last_s) begin
            state_s = WAIT;
          end else if (len_inc_s == LW'(MAX_LEN)) begin
            // Truncated: remaining words of this frame are discarded later.
            state_s = WAIT;
            err_s   = 1'b1;
            drop_s  = 1'b1;
          end else begin
            state_s = FEED;
          end
        end else begin
          state_s = FEED;
        end
      end
      WAIT: begin
        if (wait_r == WW'(LATENCY - 1)) begin
          capture_s = 1'b1;
          wait_s    = '0;
          state_s   = HOLD;
        end else begin
          wait_s    = wait_r + WW'(1);
          state_s   = WAIT;
        end
      end
      HOLD: begin
        if (hs_s) begin
          state_s = drop_r ? DROP : IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (head_last_s) begin
            drop_s  = 1'b0;
            state_s = IDLE;
          end else begin
            state_s = DROP;
          end
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state, frame counters, held engine data and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= '0;
      err_r       <= 1'b0;
      drop_r      <= 1'b0;
      wait_r      <= '0;
      crc_data_r  <= 16'h0000;
      res_valid_r <= 1'b0;
      res_crc_r   <= 16'h0000;
      res_len_r   <= '0;
      res_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      err_r   <= err_s;
      drop_r  <= drop_s;
      wait_r  <= wait_s;
      if (feed_s) crc_data_r <= head_data_s;
      if (capture_s) begin
        res_valid_r <= 1'b1;
        res_crc_r   <= crc_in;
        res_len_r   <= len_r;
        res_err_r   <= err_r;
      end else if (hs_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign crc_clear  = (state_r == CLEAR);
  assign crc_enable = feed_s;
  // During gaps the engine input keeps the last word fed.
  assign crc_data   = feed_s ? head_data_s : crc_data_r;
  assign res_valid  = res_valid_r;
  assign res_crc    = res_crc_r;
  assign res_len    = res_len_r;
  assign res_err    = res_err_r;

endmodule

// File: tb/tb_crc16_frame_feeder.sv
// Testbench for crc16_frame_feeder: a default instance (MAX_LEN=256) and a
// short-frame instance (MAX_LEN=4), each wired to a CRC-16/CCITT engine model.
module tb_crc16_frame_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_ready, crc_clear, crc_enable, res_valid, res_err;
  logic [15:0] in_data;
  logic        in_last, res_ready;
  logic [15:0] crc_data0, crc_data1, crc_in0, crc_in1, res_crc0, res_crc1;
  logic [8:0]  res_len0;
  logic [2:0]  res_len1;
  logic [15:0] eng0, eng1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int viol = 0;
  int en_cnt1 = 0;

  typedef struct { logic [15:0] crc; int len; logic err; int cyc; } res_t;
  res_t        rq0[$];
  res_t        rq1[$];
  int          en_cyc0[$];
  logic [15:0] en_dat0[$];
  int          clr_cyc0[$];

  typedef struct {
    int          n;
    logic [15:0] w [6];
    int          gap_at;
    int          exp_len;
    logic        exp_err;
  } vec_t;

  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic [15:0] p_crc0, p_crc1;
  logic [8:0]  p_len0;
  logic [2:0]  p_len1;
  logic        p_err0, p_err1;

  crc16_frame_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_last(in_last), .crc_clear(crc_clear[0]),
    .crc_enable(crc_enable[0]), .crc_data(crc_data0), .crc_in(crc_in0),
    .res_valid(res_valid[0]), .res_ready(res_ready), .res_crc(res_crc0),
    .res_len(res_len0), .res_err(res_err[0])
  );

  crc16_frame_feeder #(.DEPTH(4), .MAX_LEN(4), .LATENCY(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_last(in_last), .crc_clear(crc_clear[1]),
    .crc_enable(crc_enable[1]), .crc_data(crc_data1), .crc_in(crc_in1),
    .res_valid(res_valid[1]), .res_ready(res_ready), .res_crc(res_crc1),
    .res_len(res_len1), .res_err(res_err[1])
  );

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [15:0] frame_crc(input logic [15:0] w [6], input int n);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int k = 0; k < n; k++) r = crc_step(r, w[k]);
    return r;
  endfunction

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine models: clear or reset loads the seed, enable folds in one word.
  always @(posedge clk) begin
    if (reset || crc_clear[0]) eng0 <= 16'hFFFF;
    else if (crc_enable[0]) eng0 <= crc_step(eng0, crc_data0);
    if (reset || crc_clear[1]) eng1 <= 16'hFFFF;
    else if (crc_enable[1]) eng1 <= crc_step(eng1, crc_data1);
  end
  assign crc_in0 = eng0;
  assign crc_in1 = eng1;

  // Monitor on the falling edge: records engine traffic and result handshakes.
  initial forever begin
    @(negedge clk);
    if (crc_enable[0]) begin
      en_cyc0.push_back(cyc);
      en_dat0.push_back(crc_data0);
    end
    if (crc_clear[0]) clr_cyc0.push_back(cyc);
    if (crc_enable[1]) en_cnt1++;
    if (reset) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if ((crc_clear & crc_enable) != 2'b00) viol++;
      if (hold0 && (!res_valid[0] || res_crc0 !== p_crc0 || res_len0 !== p_len0 || res_err[0] !== p_err0)) viol++;
      if (hold1 && (!res_valid[1] || res_crc1 !== p_crc1 || res_len1 !== p_len1 || res_err[1] !== p_err1)) viol++;
      if (res_valid[0] && res_ready) rq0.push_back('{res_crc0, int'(res_len0), res_err[0], cyc});
      if (res_valid[1] && res_ready) rq1.push_back('{res_crc1, int'(res_len1), res_err[1], cyc});
      hold0 = res_valid[0] && !res_ready;
      hold1 = res_valid[1] && !res_ready;
      p_crc0 = res_crc0; p_len0 = res_len0; p_err0 = res_err[0];
      p_crc1 = res_crc1; p_len1 = res_len1; p_err1 = res_err[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [15:0] d, input logic l, output int pc);
    int guard;
    guard = 0;
    in_valid[idx] = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready[idx] && guard < 200) begin
      tick();
      guard++;
    end
    check("push_accept", guard < 200, 1'b1);
    pc = cyc;
    tick();
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_res(input int idx, input int n);
    int g;
    g = 0;
    while (((idx == 0) ? rq0.size() : rq1.size()) < n && g < 400) begin
      tick();
      g++;
    end
    check("result_arrival", g < 400, 1'b1);
  endtask

  task automatic clear_logs();
    rq0.delete(); rq1.delete(); en_cyc0.delete(); en_dat0.delete(); clr_cyc0.delete();
    en_cnt1 = 0;
  endtask

  initial begin : main
    vec_t        vt [4];
    int          pc [6];
    int          dummy, exp_en, g, base;
    logic [15:0] crc_nogap;
    logic [15:0] wa [6];
    logic [15:0] wb [6];

    reset = 1'b1; in_valid = 2'b00; in_data = 16'h0000; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready",   in_ready,   2'b00);
    check("rst_crc_clear",  crc_clear,  2'b00);
    check("rst_crc_enable", crc_enable, 2'b00);
    check("rst_crc_data",   crc_data0,  16'h0000);
    check("rst_res_valid",  res_valid,  2'b00);
    check("rst_res_crc",    res_crc0,   16'h0000);
    check("rst_res_len",    res_len0,   9'd0);
    check("rst_res_err",    res_err,    2'b00);
    reset = 1'b0;
    tick();
    check("in_ready_after_rst", in_ready, 2'b11);

    // Directed frames for the default instance
    vt[0] = '{1, '{16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, -1, 1, 1'b0};
    vt[1] = '{3, '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0}, -1, 3, 1'b0};
    vt[2] = '{3, '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0}, 0, 3, 1'b0};
    vt[3] = '{2, '{16'h0000, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0}, -1, 2, 1'b0};
    crc_nogap = 16'h0000;
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      clear_logs();
      for (int k = 0; k < vt[v].n; k++) begin
        push(0, vt[v].w[k], (k == vt[v].n - 1), pc[k]);
        if (k == vt[v].gap_at) repeat (2) tick();
      end
      wait_res(0, 1);
      check("clear_cycle", (clr_cyc0.size() > 0) ? clr_cyc0[0] : -1, pc[0] + 1);
      check("enable_count", en_cyc0.size(), vt[v].n);
      exp_en = pc[0] + 2;
      for (int k = 0; k < vt[v].n && k < en_cyc0.size(); k++) begin
        if (k > 0) exp_en = (pc[k] + 1 > exp_en + 1) ? pc[k] + 1 : exp_en + 1;
        check("enable_cycle", en_cyc0[k], exp_en);
        check("enable_data", en_dat0[k], vt[v].w[k]);
      end
      if (rq0.size() > 0) begin
        check("res_len", rq0[0].len, vt[v].exp_len);
        check("res_err", rq0[0].err, vt[v].exp_err);
        check("res_crc", rq0[0].crc, frame_crc(vt[v].w, vt[v].exp_len));
        check("res_valid_cycle", rq0[0].cyc, exp_en + 2);
        if (v == 1) crc_nogap = rq0[0].crc;
        if (v == 2) check("gap_crc_same", rq0[0].crc, crc_nogap);
      end
      repeat (2) tick();
    end

    // Five-word frame queued behind a held result: FIFO fills and in_ready drops
    clear_logs();
    res_ready = 1'b0;
    wa = '{16'hABCD, 16'h1234, 16'h0000, 16'hFFFF, 16'h8000, 16'h0};
    wb = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push(0, 16'h0001, 1'b1, dummy);
    for (int k = 0; k < 4; k++) push(0, wa[k], 1'b0, dummy);
    check("in_ready_full", in_ready[0], 1'b0);
    repeat (3) tick();
    check("in_ready_still_full", in_ready[0], 1'b0);
    check("no_feed_while_hold", en_cyc0.size(), 1);
    res_ready = 1'b1;
    push(0, 16'h8000, 1'b1, dummy);
    wait_res(0, 2);
    check("five_enable_count", en_cyc0.size(), 6);
    if (en_cyc0.size() == 6) begin
      base = en_cyc0[1];
      for (int k = 0; k < 5; k++) begin
        check("five_enable_consec", en_cyc0[k + 1], base + k);
        check("five_enable_data", en_dat0[k + 1], wa[k]);
      end
    end
    if (rq0.size() >= 2) begin
      check("one_word_crc", rq0[0].crc, frame_crc(wb, 1));
      check("one_word_len", rq0[0].len, 1);
      check("five_len", rq0[1].len, 5);
      check("five_err", rq0[1].err, 1'b0);
      check("five_crc", rq0[1].crc, frame_crc(wa, 5));
    end
    repeat (3) tick();

    // Result back-pressure: two 2-word frames, consumer stalls 6 cycles
    clear_logs();
    res_ready = 1'b0;
    wa = '{16'hA1A1, 16'hB2B2, 16'h0, 16'h0, 16'h0, 16'h0};
    wb = '{16'hC3C3, 16'hD4D4, 16'h0, 16'h0, 16'h0, 16'h0};
    push(0, wa[0], 1'b0, dummy);
    push(0, wa[1], 1'b1, dummy);
    push(0, wb[0], 1'b0, dummy);
    push(0, wb[1], 1'b1, dummy);
    g = 0;
    while (!res_valid[0] && g < 50) begin
      tick();
      g++;
    end
    check("bp_first_valid", res_valid[0], 1'b1);
    repeat (6) tick();
    check("bp_single_clear", clr_cyc0.size(), 1);
    res_ready = 1'b1;
    wait_res(0, 2);
    if (rq0.size() >= 2 && clr_cyc0.size() >= 2) begin
      check("bp_clear_after_hs", clr_cyc0[1] > rq0[0].cyc, 1'b1);
      check("bp_crc1", rq0[0].crc, frame_crc(wa, 2));
      check("bp_len1", rq0[0].len, 2);
      check("bp_crc2", rq0[1].crc, frame_crc(wb, 2));
      check("bp_len2", rq0[1].len, 2);
    end else begin
      check("bp_result_count", rq0.size() * 10 + clr_cyc0.size(), 22);
    end
    repeat (3) tick();

    // Overlength frame on the MAX_LEN=4 instance, then a normal frame
    clear_logs();
    wa = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    wb = '{16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int k = 0; k < 6; k++) push(1, wa[k], (k == 5), dummy);
    push(1, 16'h5555, 1'b1, dummy);
    wait_res(1, 2);
    check("ovl_enable_count", en_cnt1, 5);
    if (rq1.size() >= 2) begin
      check("ovl_len", rq1[0].len, 4);
      check("ovl_err", rq1[0].err, 1'b1);
      check("ovl_crc", rq1[0].crc, frame_crc(wa, 4));
      check("after_ovl_len", rq1[1].len, 1);
      check("after_ovl_err", rq1[1].err, 1'b0);
      check("after_ovl_crc", rq1[1].crc, frame_crc(wb, 1));
    end
    repeat (3) tick();

    // Reset while feeding: two words fed, third still buffered
    clear_logs();
    push(0, 16'hDEAD, 1'b0, dummy);
    push(0, 16'hBEEF, 1'b0, dummy);
    push(0, 16'hCAFE, 1'b0, dummy);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_fed_words", en_cyc0.size(), 2);
    check("mid_rst_in_ready",  in_ready[0],  1'b0);
    check("mid_rst_clear",     crc_clear[0], 1'b0);
    check("mid_rst_enable",    crc_enable[0], 1'b0);
    check("mid_rst_data",      crc_data0,    16'h0000);
    check("mid_rst_res_valid", res_valid[0], 1'b0);
    check("mid_rst_res_crc",   res_crc0,     16'h0000);
    check("mid_rst_res_len",   res_len0,     9'd0);
    check("mid_rst_res_err",   res_err[0],   1'b0);
    repeat (4) tick();
    check("fifo_flushed", en_cyc0.size(), 2);
    check("no_abandoned_result", rq0.size(), 0);
    wb = '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push(0, 16'h1234, 1'b1, dummy);
    wait_res(0, 1);
    if (rq0.size() >= 1) begin
      check("post_rst_len", rq0[0].len, 1);
      check("post_rst_err", rq0[0].err, 1'b0);
      check("post_rst_crc", rq0[0].crc, frame_crc(wb, 1));
    end
    repeat (3) tick();

    check("clear_enable_overlap_or_unstable_result", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
